// File: rtl/arb4b1_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Holds the FSM encoding, the requester index type and the hold default.
package arb4b1_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } state_e;

    typedef logic [1:0] idx_t;

    localparam logic [3:0] MAX_HOLD_DEF = 4'd15;

    function automatic logic [3:0] onehot4(input idx_t i);
        return 4'b0001 << i;
    endfunction

endpackage

// File: rtl/arb4b1_rr_if.sv
// Request/grant bundle of the arbiter: requests toward it, grant status back.
// master drives i0..i3 and observes g/gv/o; slave is the arbiter side.
interface arb4b1_rr_if;

    logic       i0;
    logic       i1;
    logic       i2;
    logic       i3;
    logic [3:0] g;
    logic       gv;
    logic       o;

    modport master (
        output i0, i1, i2, i3,
        input  g, gv, o
    );

    modport slave (
        input  i0, i1, i2, i3,
        output g, gv, o
    );

endinterface

// File: rtl/arb4b1_rr_pick4.sv
// Combinational rotation picker: first set request after LAST, wrapping.
// Ports: r[3:0] effective requests, last previous winner -> win, found.
module rr_pick4
    import arb4b1_pkg::*;
(
    input  logic [3:0] r,
    input  idx_t       last,
    output idx_t       win,
    output logic       found
);

    idx_t cand;

    // Scan from lowest to highest priority so the highest-priority
    // hit (LAST+1) is the final assignment that survives.
    always_comb begin
        win   = last;
        found = 1'b0;
        cand  = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + idx_t'(k);
            if (r[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb4b1_rr.sv
// 4-requester round-robin arbiter with hold-time preemption and a
// one-cycle recovery gap. Ports: C clock, CLR async reset, I0 (active-low),
// I1..I3 requests; G one-hot grant, GV grant valid, O registered any-request.
module arb4b1_rr
    import arb4b1_pkg::*;
#(
    parameter logic [3:0] MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic       C,
    input  logic       CLR,
    input  logic       I0,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    output logic [3:0] G,
    output logic       GV,
    output logic       O
);

    state_e     state_q, state_d;
    logic [3:0] g_q, g_d;
    logic       gv_q, gv_d;
    logic       o_q, o_d;
    logic [3:0] hc_q, hc_d;
    idx_t       last_q, last_d;

    logic [3:0] r;
    idx_t       win;
    logic       found;
    logic       arb;
    logic       others;
    logic       expired;

    assign r = {I3, I2, I1, ~I0};

    rr_pick4 u_pick (
        .r     (r),
        .last  (last_q),
        .win   (win),
        .found (found)
    );

    // While granted, LAST is the owner.
    assign others  = |(r & ~onehot4(last_q));
    // hc >= MAX_HOLD, written as hc + 1 > MAX_HOLD in 5 bits.
    assign expired = (MAX_HOLD != 4'd0) &&
                     (({1'b0, hc_q} + 5'd1) > {1'b0, MAX_HOLD});

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        gv_d    = gv_q;
        hc_d    = hc_q;
        last_d  = last_q;
        o_d     = |r;
        arb     = 1'b0;
        unique case (state_q)
            IDLE:    arb = 1'b1;
            RECOVER: arb = 1'b1;
            GRANT: begin
                if (!r[last_q] || (expired && others)) begin
                    state_d = RECOVER;
                    g_d     = 4'b0000;
                    gv_d    = 1'b0;
                end else if (hc_q != 4'hF) begin
                    hc_d = hc_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                g_d     = 4'b0000;
                gv_d    = 1'b0;
            end
        endcase
        if (arb) begin
            if (found) begin
                state_d = GRANT;
                g_d     = onehot4(win);
                gv_d    = 1'b1;
                last_d  = win;
                hc_d    = 4'd0;
            end else begin
                state_d = IDLE;
                g_d     = 4'b0000;
                gv_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            g_q     <= 4'b0000;
            gv_q    <= 1'b0;
            o_q     <= 1'b0;
            hc_q    <= 4'd0;
            last_q  <= idx_t'(3);
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            gv_q    <= gv_d;
            o_q     <= o_d;
            hc_q    <= hc_d;
            last_q  <= last_d;
        end
    end

    assign G  = g_q;
    assign GV = gv_q;
    assign O  = o_q;

endmodule

// File: tb/tb_arb4b1_rr.sv
// Directed-vector bench for arb4b1_rr: round-robin table plus reset,
// preemption, no-preemption, mid-grant reset and sole-requester sequences.
module tb_arb4b1_rr;

    typedef struct {
        logic [3:0] req;
        logic [3:0] g;
        logic       gv;
        logic       o;
    } vec_t;

    logic clk;
    logic clr;
    logic clr_p;
    logic clr_n;
    int   n_vec;
    int   n_bad;
    vec_t vecs [21];

    arb4b1_rr_if bus ();
    arb4b1_rr_if bus_p ();
    arb4b1_rr_if bus_n ();

    arb4b1_rr #(.MAX_HOLD(4'd15)) dut (
        .C(clk), .CLR(clr),
        .I0(bus.i0), .I1(bus.i1), .I2(bus.i2), .I3(bus.i3),
        .G(bus.g), .GV(bus.gv), .O(bus.o)
    );

    arb4b1_rr #(.MAX_HOLD(4'd3)) dut_p (
        .C(clk), .CLR(clr_p),
        .I0(bus_p.i0), .I1(bus_p.i1), .I2(bus_p.i2), .I3(bus_p.i3),
        .G(bus_p.g), .GV(bus_p.gv), .O(bus_p.o)
    );

    arb4b1_rr #(.MAX_HOLD(4'd0)) dut_n (
        .C(clk), .CLR(clr_n),
        .I0(bus_n.i0), .I1(bus_n.i1), .I2(bus_n.i2), .I3(bus_n.i3),
        .G(bus_n.g), .GV(bus_n.gv), .O(bus_n.o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [3:0] ag, input logic agv, input logic ao,
                       input logic [3:0] eg, input logic egv, input logic eo);
        n_vec++;
        if ({ag, agv, ao} !== {eg, egv, eo}) begin
            n_bad++;
            $display("FAIL %s: got G=%b GV=%b O=%b, want G=%b GV=%b O=%b",
                     name, ag, agv, ao, eg, egv, eo);
        end
    endtask

    task automatic set_main(input logic [3:0] r);
        bus.i0 = ~r[0];
        bus.i1 = r[1];
        bus.i2 = r[2];
        bus.i3 = r[3];
    endtask

    task automatic set_p(input logic [3:0] r);
        bus_p.i0 = ~r[0];
        bus_p.i1 = r[1];
        bus_p.i2 = r[2];
        bus_p.i3 = r[3];
    endtask

    task automatic set_n(input logic [3:0] r);
        bus_n.i0 = ~r[0];
        bus_n.i1 = r[1];
        bus_n.i2 = r[2];
        bus_n.i3 = r[3];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] pre_g [6];

    initial begin
        n_vec = 0;
        n_bad = 0;
        clr   = 1'b1;
        clr_p = 1'b1;
        clr_n = 1'b1;
        set_main(4'b0000);
        set_p(4'b0000);
        set_n(4'b0000);

        // r = {r3,r2,r1,r0}
        vecs[0]  = '{4'b1111, 4'b0001, 1'b1, 1'b1};
        vecs[1]  = '{4'b1111, 4'b0001, 1'b1, 1'b1};
        vecs[2]  = '{4'b1110, 4'b0000, 1'b0, 1'b1};
        vecs[3]  = '{4'b1111, 4'b0010, 1'b1, 1'b1};
        vecs[4]  = '{4'b1111, 4'b0010, 1'b1, 1'b1};
        vecs[5]  = '{4'b1101, 4'b0000, 1'b0, 1'b1};
        vecs[6]  = '{4'b1111, 4'b0100, 1'b1, 1'b1};
        vecs[7]  = '{4'b1111, 4'b0100, 1'b1, 1'b1};
        vecs[8]  = '{4'b1011, 4'b0000, 1'b0, 1'b1};
        vecs[9]  = '{4'b1111, 4'b1000, 1'b1, 1'b1};
        vecs[10] = '{4'b1111, 4'b1000, 1'b1, 1'b1};
        vecs[11] = '{4'b0111, 4'b0000, 1'b0, 1'b1};
        vecs[12] = '{4'b1111, 4'b0001, 1'b1, 1'b1};
        vecs[13] = '{4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[14] = '{4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[15] = '{4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[16] = '{4'b1000, 4'b1000, 1'b1, 1'b1};
        vecs[17] = '{4'b0010, 4'b0000, 1'b0, 1'b1};
        vecs[18] = '{4'b1010, 4'b0010, 1'b1, 1'b1};
        vecs[19] = '{4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[20] = '{4'b0000, 4'b0000, 1'b0, 1'b0};

        // Reset with requests present: outputs held low asynchronously.
        #3;
        set_main(4'b0011);
        #1;
        chk("reset_hold", bus.g, bus.gv, bus.o, 4'b0000, 1'b0, 1'b0);
        step();
        chk("reset_edge", bus.g, bus.gv, bus.o, 4'b0000, 1'b0, 1'b0);
        clr = 1'b0;
        step();
        chk("reset_first_arb", bus.g, bus.gv, bus.o, 4'b0001, 1'b1, 1'b1);

        // Round-robin table from a fresh reset.
        clr = 1'b1;
        set_main(4'b0000);
        step();
        clr = 1'b0;
        for (int i = 0; i < 21; i++) begin
            set_main(vecs[i].req);
            step();
            chk($sformatf("rr_vec%0d", i), bus.g, bus.gv, bus.o,
                vecs[i].g, vecs[i].gv, vecs[i].o);
        end

        // Sole requester: grant, release, re-raise during RECOVER.
        clr = 1'b1;
        step();
        clr = 1'b0;
        set_main(4'b0100);
        step();
        chk("sole_grant", bus.g, bus.gv, bus.o, 4'b0100, 1'b1, 1'b1);
        set_main(4'b0000);
        step();
        chk("sole_recover", bus.g, bus.gv, bus.o, 4'b0000, 1'b0, 1'b0);
        set_main(4'b0100);
        step();
        chk("sole_regrant", bus.g, bus.gv, bus.o, 4'b0100, 1'b1, 1'b1);

        // Mid-grant reset pulse between edges; LAST returns to 3.
        set_main(4'b1111);
        clr = 1'b1;
        #1;
        chk("midreset_drop", bus.g, bus.gv, bus.o, 4'b0000, 1'b0, 1'b0);
        #1;
        clr = 1'b0;
        step();
        chk("midreset_rearb", bus.g, bus.gv, bus.o, 4'b0001, 1'b1, 1'b1);

        // Preemption with MAX_HOLD=3: requester 1 holds, 2 waits.
        pre_g[0] = 4'b0010;
        pre_g[1] = 4'b0010;
        pre_g[2] = 4'b0010;
        pre_g[3] = 4'b0010;
        pre_g[4] = 4'b0000;
        pre_g[5] = 4'b0100;
        set_p(4'b0110);
        clr_p = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("preempt_c%0d", i), bus_p.g, bus_p.gv, bus_p.o,
                pre_g[i], pre_g[i] != 4'b0000, 1'b1);
        end

        // No preemption with MAX_HOLD=0: requester 3 keeps the grant.
        set_n(4'b1000);
        clr_n = 1'b0;
        step();
        chk("nopre_grant", bus_n.g, bus_n.gv, bus_n.o, 4'b1000, 1'b1, 1'b1);
        set_n(4'b1001);
        for (int i = 0; i < 40; i++) begin
            step();
            chk($sformatf("nopre_c%0d", i), bus_n.g, bus_n.gv, bus_n.o,
                4'b1000, 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/arb4b1_rr.md
ARB4B1_RR -- requirements
Module: arb4b1_rr

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4'd15, meaning the maximum grant cycles before preemption when others wait; 0 disables preemption.
REQ-002 SHALL have port C, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port CLR, input, 1, the asynchronous, active-high reset.
REQ-004 SHALL have port I0, input, 1, requester 0 request, active-low (effective request r0 = ~I0).
REQ-005 SHALL have ports I1, I2 and I3, input, 1 each, requester 1-3 requests, active-high (r1..r3).
REQ-006 SHALL have port G, output, 4, registered one-hot grant (G[k] grants requester k).
REQ-007 SHALL have port GV, output, 1, registered; high iff G is nonzero.
REQ-008 SHALL have port O, output, 1, registered OR of effective requests r0|r1|r2|r3.

Function
REQ-009 SHALL implement FSM states IDLE, GRANT and RECOVER.
REQ-010 IDLE: if any r is high at an edge, SHALL pick a winner and enter GRANT; G and GV assert at that same edge (1-cycle latency from sampled request); else remain in IDLE.
REQ-011 Winner SHALL be the first requester with r high in rotation order LAST+1, LAST+2, LAST+3, LAST (mod 4), where LAST is the index of the previous winner.
REQ-012 On each grant, LAST SHALL update to the winner index.
REQ-013 GRANT: SHALL hold G constant while the owner's r stays high; hold counter HC (4-bit) increments each cycle in GRANT and saturates at 15.
REQ-014 GRANT -> RECOVER SHALL occur when the owner's r is low (release).
REQ-015 GRANT -> RECOVER SHALL also occur when MAX_HOLD != 0, HC >= MAX_HOLD and any non-owner r is high (preemption).
REQ-016 Simultaneous release and preemption condition SHALL be treated as a release; the result is identical.
REQ-017 RECOVER: G=0 and GV=0 for exactly one cycle; SHALL re-arbitrate per REQ-011 at the exit edge, entering GRANT if any r is high, else IDLE.
REQ-018 Requests arriving or dropping during RECOVER SHALL be honoured at the RECOVER exit edge.
REQ-019 HC SHALL clear to 0 on every entry into GRANT.
REQ-020 A requester SHALL NOT be granted in back-to-back grants while another r is high (rotation guarantee); a sole requester may be re-granted after RECOVER.
REQ-021 O SHALL equal the OR of r sampled at the previous edge, independent of FSM state.
REQ-022 G SHALL never have more than one bit set.

Reset
REQ-023 CLR high SHALL asynchronously force state=IDLE, G=4'b0000, GV=0, O=0, HC=0 and LAST=3, so requester 0 has first priority after reset.
REQ-024 CLR asserted mid-grant SHALL drop G immediately, without waiting for C.
REQ-025 After CLR deasserts, the first arbitration SHALL occur on the next rising edge of C.

Structure
REQ-026 Shared package arb4b1_pkg SHALL hold the state encoding (IDLE=2'd0, GRANT=2'd1, RECOVER=2'd2), the 2-bit index type and the MAX_HOLD default constant.
REQ-027 The rotation picker SHALL be a combinational sub-module rr_pick4 (inputs: r[3:0], LAST; outputs: winner index, found).
REQ-028 The FSM, HC, LAST and output registers SHALL reside in arb4b1_rr.

Verification
REQ-029 Reset: CLR=1 with I0=0 and I1=1 -> G=0000, GV=0 and O=0 immediately; after CLR falls, the next edge gives G=0001, GV=1 and O=1.
REQ-030 Round-robin: all four requesting (I0=0, I1..I3=1), each owner releasing after 2 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, with one G=0000 cycle between grants.
REQ-031 Preemption: MAX_HOLD=3, requester 1 holds, requester 2 requests -> G=0010 for 4 cycles, then 0000 for one cycle, then 0100.
REQ-032 No preemption: MAX_HOLD=0, requester 3 holds for 40 cycles while requester 0 waits -> G stays 1000 for all 40 cycles.
REQ-033 Mid-grant reset: with G=0100, pulse CLR between edges -> G=0000 within the pulse, and the next arbitration starts from LAST=3.
REQ-034 Sole requester: only I2=1, released and re-raised during RECOVER -> G sequence 0100, 0000, 0100.
